// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// FSM state encoding and counter sizing helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor slice: d = x - y - bi.
// Purely combinational; borrow-out on bo.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, one bit per clock.
// Result and borrow are registered on the final shift cycle.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_sa;
  logic [W-1:0]   r_sb;
  logic [W-1:0]   r_sr;
  logic           r_br;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_diff;
  logic           r_bout;
  logic           w_d;
  logic           w_bo;
  logic           w_accept;
  logic           w_last;
  logic           w_busy;
  logic           w_done;

  assign w_accept = start &&
                    (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);

  full_sub_cell u_cell (
    .x  (r_sa[0]),
    .y  (r_sb[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      SHIFT:   w_busy = 1'b1;
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  assign busy = w_busy;
  assign done = w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sr   <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_sa  <= a;
      r_sb  <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_sa  <= {1'b0, r_sa[W-1:1]};
      r_sb  <= {1'b0, r_sb[W-1:1]};
      r_sr  <= {w_d, r_sr[W-1:1]};
      r_br  <= w_bo;
      r_cnt <= r_cnt + CW'(1);
      // Final bit: publish result in the same edge that enters DONE
      if (w_last) begin
        r_diff <= {w_d, r_sr[W-1:1]};
        r_bout <= w_bo;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

endmodule
